// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_WR
  } state_t;

  // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_radix2.sv
// Restoring radix-2 divider on magnitudes: 32 iteration cycles, then one sign-fix cycle
// during which done is high and the signed quotient/remainder are presented.
module mdu_div_radix2
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES);

  logic          run;
  logic          fix;
  logic [CW-1:0] cnt;
  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic          neg_q;
  logic          neg_r;
  logic          dz;

  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;

  assign shifted = {rem, quo[31]};
  assign ge      = shifted >= {1'b0, dvs};
  // Only used when ge holds, so the result always fits in 32 bits.
  assign diff    = shifted[31:0] - dvs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run   <= 1'b0;
      fix   <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      fix <= 1'b0;
      if (start) begin
        run   <= 1'b1;
        cnt   <= CW'(DIV_CYCLES - 1);
        rem   <= '0;
        quo   <= magnitude(dividend, is_signed);
        dvs   <= magnitude(divisor, is_signed);
        neg_q <= is_signed & (dividend[31] ^ divisor[31]);
        neg_r <= is_signed & dividend[31];
        dz    <= (divisor == 32'd0);
      end else if (abort) begin
        run <= 1'b0;
      end else if (run) begin
        rem <= ge ? diff : shifted[31:0];
        quo <= {quo[30:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          run <= 1'b0;
          fix <= 1'b1;
        end
      end
    end
  end

  assign last = run && (cnt == '0);
  assign done = fix;

  // A zero divisor leaves |dividend| in rem, so the remainder path already yields rs.
  assign quotient  = dz ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
  assign remainder = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning HI/LO: background MULT/DIV/MTHI/MTLO with a one-cycle
// commit-check window in which an exception flush can still kill the operation.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_en,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  logic        check;
  logic [1:0]  mul_cnt;
  logic        wr_hi;
  logic [31:0] wr_data;
  logic [63:0] mul_pipe [MUL_STAGES];

  logic        start;
  logic        is_mul;
  logic        is_div;
  logic        is_mt;
  logic        kill;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  logic        div_last;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign start  = ex_en && (op != OP_NOP) && (state == ST_IDLE);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
  assign kill   = check && cancel;
  assign busy   = start || (state != ST_IDLE);

  // The low 64 bits of a 64x64 product of extended operands are exact for both signednesses.
  assign mul_a = (op == OP_MULT) ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign mul_b = (op == OP_MULT) ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
  assign prod  = mul_a * mul_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else begin
      if (start && is_mul) mul_pipe[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  mdu_div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start && is_div),
    .abort     (kill && (state == ST_DIV)),
    .is_signed (op == OP_DIV),
    .dividend  (rs_val),
    .divisor   (rt_val),
    .last      (div_last),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      check   <= 1'b0;
      mul_cnt <= '0;
      wr_hi   <= 1'b0;
      wr_data <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      check <= start;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              state   <= ST_MUL;
              mul_cnt <= 2'(MUL_STAGES - 1);
            end else if (is_div) begin
              state <= ST_DIV;
            end else if (is_mt) begin
              state   <= ST_WR;
              wr_hi   <= (op == OP_MTHI);
              wr_data <= rs_val;
            end
          end
        end
        ST_MUL: begin
          if (kill) begin
            state <= ST_IDLE;
          end else if (mul_cnt == 2'd0) begin
            {hi, lo} <= mul_pipe[MUL_STAGES-1];
            state    <= ST_IDLE;
          end else begin
            mul_cnt <= mul_cnt - 2'd1;
          end
        end
        ST_DIV: begin
          if (kill) state <= ST_IDLE;
          else if (div_last) state <= ST_FIX;
        end
        ST_FIX: begin
          if (div_done) begin
            hi <= div_rem;
            lo <= div_quo;
          end
          state <= ST_IDLE;
        end
        ST_WR: begin
          if (!kill) begin
            if (wr_hi) hi <= wr_data;
            else lo <= wr_data;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: each op pushes its expected HI/LO and busy length,
// a negedge monitor pops and checks when busy falls.
module tb_mdu_hilo;
  import mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_en = 1'b0;
  logic [2:0]  op = OP_NOP;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mdu_hilo #(.MUL_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .ex_en  (ex_en),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: busy high->low marks the end of an op (commit, cancel or reset).
  logic        prev_busy = 1'b0;
  int          busy_cyc = 0;
  logic [31:0] pre_hi = '0;
  logic [31:0] pre_lo = '0;
  logic        moved = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (ex_en && op != OP_NOP && dut.state != ST_IDLE) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_while_busy: op %0d launched with state %0d", op, dut.state);
    end
    if (busy) begin
      if (!prev_busy) begin
        busy_cyc = 1;
        pre_hi   = hi;
        pre_lo   = lo;
        moved    = 1'b0;
      end else begin
        busy_cyc++;
        if (hi !== pre_hi || lo !== pre_lo) moved = 1'b1;
      end
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_end: busy fell with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        cmp({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        cmp({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        cmp({e.name, "_busy_cycles"}, 64'(busy_cyc), 64'(e.cycles));
        cmp({e.name, "_hilo_stable"}, 64'(moved), 64'd0);
      end
    end
    prev_busy = busy;
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input int rst_at, input string nm,
                        input logic [31:0] eh, input logic [31:0] el, input int ecyc);
    int k;
    exp_q.push_back('{nm, eh, el, ecyc});
    @(posedge clk); #1;
    ex_en  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    cancel = (cancel_at == 0);
    @(posedge clk); #1;
    k      = 1;
    ex_en  = 1'b0;
    op     = OP_NOP;
    rs_val = '0;
    rt_val = '0;
    cancel = (cancel_at == 1);
    while (busy && k < 80) begin
      @(posedge clk); #1;
      k++;
      cancel = (cancel_at == k);
      if (k == rst_at) rst = 1'b0;
    end
    cancel = 1'b0;
    if (k >= 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still high after %0d cycles, limit 80", nm, k);
    end
    if (rst_at > 0) begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_hi", 64'(hi), 64'd0);
    cmp("reset_lo", 64'(lo), 64'd0);
    cmp("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(OP_MULT,  32'hFFFFFFFE, 32'h3, -1, -1, "mult_neg",   32'hFFFFFFFF, 32'hFFFFFFFA, 3);
    run_op(OP_MULTU, 32'hFFFFFFFE, 32'h3, -1, -1, "multu",      32'h00000002, 32'hFFFFFFFA, 3);
    run_op(OP_MULT,  32'h80000000, 32'h80000000, -1, -1, "mult_min", 32'h40000000, 32'h0, 3);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h2, -1, -1, "div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op(OP_DIV,   32'h7, 32'hFFFFFFFE, -1, -1, "div_7_neg2", 32'h00000001, 32'hFFFFFFFD, 34);
    run_op(OP_DIVU,  32'd100, 32'd7, -1, -1, "divu_100_7",      32'h00000002, 32'h0000000E, 34);
    run_op(OP_DIVU,  32'h12345678, 32'h0, -1, -1, "divu_by0",   32'h12345678, 32'hFFFFFFFF, 34);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h0, -1, -1, "div_by0",    32'hFFFFFFF9, 32'hFFFFFFFF, 34);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, -1, -1, "div_ovf", 32'h0, 32'h80000000, 34);
    run_op(OP_MTHI,  32'hA5A5A5A5, 32'h0, -1, -1, "mthi_pre",   32'hA5A5A5A5, 32'h80000000, 2);
    run_op(OP_MTLO,  32'hA5A5A5A5, 32'h0, -1, -1, "mtlo_pre",   32'hA5A5A5A5, 32'hA5A5A5A5, 2);
    run_op(OP_MULT,  32'd5, 32'd7, 1, -1, "mult_cancel",        32'hA5A5A5A5, 32'hA5A5A5A5, 2);
    run_op(OP_DIVU,  32'd100, 32'd7, 1, -1, "divu_cancel",      32'hA5A5A5A5, 32'hA5A5A5A5, 2);
    run_op(OP_MULT,  32'd5, 32'd7, 2, -1, "mult_late_cancel",   32'h0, 32'h00000023, 3);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, "multu_start_cancel", 32'hFFFFFFFE, 32'h1, 3);
    run_op(OP_MTLO,  32'hCAFEBABE, 32'h0, -1, -1, "mtlo",       32'hFFFFFFFE, 32'hCAFEBABE, 2);
    run_op(OP_MTHI,  32'h12345678, 32'h0, 1, -1, "mthi_cancel", 32'hFFFFFFFE, 32'hCAFEBABE, 2);
    run_op(OP_DIVU,  32'hFFFFFFFF, 32'd3, -1, 15, "div_reset",  32'h0, 32'h0, 15);
    run_op(OP_DIVU,  32'd9, 32'd3, -1, -1, "divu_after_rst",    32'h0, 32'h3, 34);

    repeat (3) @(posedge clk);
    #1;
    cmp("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
